// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking slot manager.
// Status codes and FSM states used by the top and the bench.
package parking_pkg;

    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_VNO_W     = 32;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_FULL      = 2'd1,
        ST_DUP       = 2'd2,
        ST_NOT_FOUND = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/parking_slot_table.sv
// Per-slot vehicle number storage with valid bits.
// One combinational read index, one set port, one clear port.
module parking_slot_table #(
    parameter int NUM_SLOTS = 8,
    parameter int VNO_W     = 32,
    localparam int IW       = $clog2(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    rd_idx,
    output logic             rd_valid,
    output logic [VNO_W-1:0] rd_vno,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [VNO_W-1:0] wr_vno,
    input  logic             clr_en,
    input  logic [IW-1:0]    clr_idx
);

    logic [NUM_SLOTS-1:0] valid_q;
    logic [VNO_W-1:0]     vno_q [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (wr_en) valid_q[wr_idx] <= 1'b1;
            if (clr_en) valid_q[clr_idx] <= 1'b0;
        end
    end

    // Payload needs no reset: it is only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) vno_q[wr_idx] <= wr_vno;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_vno   = vno_q[rd_idx];

endmodule

// File: rtl/parking_slot_manager.sv
// Assigns parking slots on entry edges and frees them on exit requests.
// Fixed-latency linear search over the slot table, one slot per cycle.
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int VNO_W     = DEF_VNO_W,
    localparam int IW       = $clog2(NUM_SLOTS),
    localparam int CW       = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_parked,
    input  logic [VNO_W-1:0] vehicle_no,
    input  logic             exit_req,
    input  logic [VNO_W-1:0] exit_vehicle_no,
    output logic             ready,
    output logic             exit_ack,
    output logic             done,
    output logic             op_exit,
    output logic [1:0]       status,
    output logic [IW-1:0]    slot_id,
    output logic [CW-1:0]    occupancy,
    output logic             full,
    output logic             empty,
    output logic             entry_lost
);

    state_t           state;
    logic             car_parked_q;
    logic             pend_v;
    logic [VNO_W-1:0] pend_vno;
    logic [VNO_W-1:0] key;
    logic             is_exit;
    logic [IW-1:0]    idx;
    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic             dup;
    logic [CW-1:0]    occ;
    logic             done_q;
    logic             op_exit_q;
    status_t          status_q;
    logic [IW-1:0]    slot_q;

    logic             rd_valid;
    logic [VNO_W-1:0] rd_vno;
    logic             entry_edge;
    logic             take_entry;
    logic             take_exit;
    logic             last;
    logic             match;
    logic             commit;
    logic             hit_n;
    logic [IW-1:0]    hit_idx_n;
    logic             dup_n;
    logic             wr_en;
    logic             clr_en;
    status_t          res_status;
    logic [IW-1:0]    res_slot;

    assign entry_edge = car_parked & ~car_parked_q & ~reset;
    assign take_entry = (state == IDLE) & pend_v;
    // A fresh entry edge blocks exit acceptance so the entry wins.
    assign take_exit  = (state == IDLE) & ~pend_v & ~entry_edge
                      & exit_req & ~reset;
    assign last       = (idx == IW'(NUM_SLOTS - 1));
    assign match      = rd_valid & (rd_vno == key);
    assign commit     = (state == SEARCH) & last;

    always_comb begin
        hit_n     = hit;
        hit_idx_n = hit_idx;
        dup_n     = dup;
        if (state == SEARCH) begin
            if (!hit && (is_exit ? match : !rd_valid)) begin
                hit_n     = 1'b1;
                hit_idx_n = idx;
            end
            if (!is_exit && match) dup_n = 1'b1;
        end
    end

    always_comb begin
        res_status = ST_OK;
        res_slot   = hit_idx_n;
        unique case (1'b1)
            (is_exit && !hit_n): begin
                res_status = ST_NOT_FOUND;
                res_slot   = '0;
            end
            (!is_exit && dup_n): begin
                res_status = ST_DUP;
                res_slot   = '0;
            end
            (!is_exit && !dup_n && !hit_n): begin
                res_status = ST_FULL;
                res_slot   = '0;
            end
            default: begin
                res_status = ST_OK;
                res_slot   = hit_idx_n;
            end
        endcase
    end

    assign wr_en  = commit & ~is_exit & ~dup_n & hit_n;
    assign clr_en = commit & is_exit & hit_n;

    parking_slot_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .VNO_W     (VNO_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_vno   (rd_vno),
        .wr_en    (wr_en),
        .wr_idx   (hit_idx_n),
        .wr_vno   (key),
        .clr_en   (clr_en),
        .clr_idx  (hit_idx_n)
    );

    // Loads during reset too, so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        car_parked_q <= car_parked;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend_v    <= 1'b0;
            pend_vno  <= '0;
            key       <= '0;
            is_exit   <= 1'b0;
            idx       <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            dup       <= 1'b0;
            occ       <= '0;
            done_q    <= 1'b0;
            op_exit_q <= 1'b0;
            status_q  <= ST_OK;
            slot_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (entry_edge && (!pend_v || take_entry)) begin
                pend_v   <= 1'b1;
                pend_vno <= vehicle_no;
            end else if (take_entry) begin
                pend_v <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (take_entry) begin
                        state   <= SEARCH;
                        is_exit <= 1'b0;
                        key     <= pend_vno;
                        idx     <= '0;
                        hit     <= 1'b0;
                        hit_idx <= '0;
                        dup     <= 1'b0;
                    end else if (take_exit) begin
                        state   <= SEARCH;
                        is_exit <= 1'b1;
                        key     <= exit_vehicle_no;
                        idx     <= '0;
                        hit     <= 1'b0;
                        hit_idx <= '0;
                        dup     <= 1'b0;
                    end
                end
                SEARCH: begin
                    hit     <= hit_n;
                    hit_idx <= hit_idx_n;
                    dup     <= dup_n;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        state     <= RESP;
                        done_q    <= 1'b1;
                        op_exit_q <= is_exit;
                        status_q  <= res_status;
                        slot_q    <= res_slot;
                        if (wr_en) occ <= occ + 1'b1;
                        else if (clr_en) occ <= occ - 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready      = (state == IDLE) & ~pend_v;
    assign exit_ack   = take_exit;
    assign entry_lost = entry_edge & pend_v & ~take_entry;
    assign done       = done_q;
    assign op_exit    = done_q & op_exit_q;
    assign status     = done_q ? status_q : 2'b00;
    assign slot_id    = done_q ? slot_q : '0;
    assign occupancy  = occ;
    assign full       = (occ == CW'(NUM_SLOTS));
    assign empty      = (occ == '0);

endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboard bench for parking_slot_manager with four slots.
// Stimulus pushes expected responses; a monitor checks each done pulse.
module tb_parking_slot_manager;
    import parking_pkg::*;

    localparam int N  = 4;
    localparam int VW = 32;
    localparam int IW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          car_parked = 1'b0;
    logic [VW-1:0] vehicle_no = '0;
    logic          exit_req = 1'b0;
    logic [VW-1:0] exit_vehicle_no = '0;
    logic          ready;
    logic          exit_ack;
    logic          done;
    logic          op_exit;
    logic [1:0]    status;
    logic [IW-1:0] slot_id;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          empty;
    logic          entry_lost;

    always #5 clk = ~clk;

    parking_slot_manager #(.NUM_SLOTS(N), .VNO_W(VW)) dut (
        .clk             (clk),
        .reset           (reset),
        .car_parked      (car_parked),
        .vehicle_no      (vehicle_no),
        .exit_req        (exit_req),
        .exit_vehicle_no (exit_vehicle_no),
        .ready           (ready),
        .exit_ack        (exit_ack),
        .done            (done),
        .op_exit         (op_exit),
        .status          (status),
        .slot_id         (slot_id),
        .occupancy       (occupancy),
        .full            (full),
        .empty           (empty),
        .entry_lost      (entry_lost)
    );

    typedef struct {
        logic          op;
        logic [1:0]    st;
        logic [IW-1:0] slot;
        logic [CW-1:0] occ;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    int lost_cnt = 0;
    int done_cyc = 0;
    int ack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("op_exit", op_exit, e.op);
                chk("status", status, e.st);
                chk("slot_id", slot_id, e.slot);
                chk("occupancy", occupancy, e.occ);
            end
        end
        if (exit_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (entry_lost) lost_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input status_t st,
                        input int slot, input int occ);
        exp_t e;
        e.op   = op;
        e.st   = st;
        e.slot = IW'(slot);
        e.occ  = CW'(occ);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 60) begin
            tick();
            t++;
        end
        chk("ready_timeout", ready, 1);
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 60) begin
            tick();
            t++;
        end
        chk("done_timeout", done_cnt >= target, 1);
    endtask

    task automatic wait_ack(input int a);
        int t = 0;
        while (ack_cnt == a && t < 60) begin
            tick();
            t++;
        end
        chk("exit_ack_seen", ack_cnt - a, 1);
    endtask

    task automatic entry(input int v, input status_t st, input int slot,
                         input int occ, input int hold);
        int c;
        int tgt;
        tick();
        wait_ready();
        push(1'b0, st, slot, occ);
        tgt = done_cnt + 1;
        car_parked = 1'b1;
        vehicle_no = VW'(v);
        c = cyc;
        tick(hold);
        car_parked = 1'b0;
        wait_done(tgt);
        chk("entry_latency", done_cyc - c, N + 2);
    endtask

    task automatic leave(input int v, input status_t st, input int slot,
                         input int occ);
        int a;
        int tgt;
        tick();
        wait_ready();
        push(1'b1, st, slot, occ);
        tgt = done_cnt + 1;
        a = ack_cnt;
        exit_req = 1'b1;
        exit_vehicle_no = VW'(v);
        wait_ack(a);
        exit_req = 1'b0;
        wait_done(tgt);
        chk("exit_latency", done_cyc - ack_cyc, N + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int d;
        int l;
        int tgt;
        tick(3);
        reset = 1'b0;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_exit_ack", exit_ack, 0);
        chk("rst_entry_lost", entry_lost, 0);
        chk("rst_status", status, 0);
        chk("rst_slot_id", slot_id, 0);
        chk("rst_op_exit", op_exit, 0);

        entry(1104, ST_OK, 0, 1, 10);
        entry(2501, ST_OK, 1, 2, 10);
        entry(5601, ST_OK, 2, 3, 10);
        chk("occ_after_three", occupancy, 3);

        entry(1104, ST_DUP, 0, 3, 4);
        entry(7777, ST_OK, 3, 4, 4);
        entry(8888, ST_FULL, 0, 4, 4);
        chk("full_flag", full, 1);
        chk("empty_flag", empty, 0);
        entry(5601, ST_DUP, 0, 4, 4);

        leave(2501, ST_OK, 1, 3);
        chk("full_cleared", full, 0);
        entry(9999, ST_OK, 1, 4, 4);
        leave(4242, ST_NOT_FOUND, 0, 4);

        // entry edge and exit request in the same idle cycle
        tick();
        wait_ready();
        push(1'b0, ST_FULL, 0, 4);
        push(1'b1, ST_OK, 3, 3);
        tgt = done_cnt + 2;
        a = ack_cnt;
        car_parked = 1'b1;
        vehicle_no = 3333;
        exit_req = 1'b1;
        exit_vehicle_no = 7777;
        wait_ack(a);
        exit_req = 1'b0;
        car_parked = 1'b0;
        chk("ack_after_entry_resp", ack_cyc - done_cyc, 1);
        wait_done(tgt);

        // three edges while busy: first pends, two are dropped
        tick();
        wait_ready();
        push(1'b0, ST_OK, 3, 4);
        push(1'b0, ST_DUP, 0, 4);
        tgt = done_cnt + 2;
        l = lost_cnt;
        car_parked = 1'b1;
        vehicle_no = 4444;
        tick();
        car_parked = 1'b0;
        tick();
        car_parked = 1'b1;
        vehicle_no = 1104;
        tick();
        car_parked = 1'b0;
        tick();
        car_parked = 1'b1;
        vehicle_no = 6666;
        tick();
        car_parked = 1'b0;
        tick();
        car_parked = 1'b1;
        vehicle_no = 7777;
        tick();
        car_parked = 1'b0;
        wait_done(tgt);
        chk("entry_lost_count", lost_cnt - l, 2);

        // reset in the middle of an exit search
        tick();
        wait_ready();
        a = ack_cnt;
        d = done_cnt;
        l = lost_cnt;
        exit_req = 1'b1;
        exit_vehicle_no = 5601;
        wait_ack(a);
        exit_req = 1'b0;
        tick();
        reset = 1'b1;
        car_parked = 1'b1;
        vehicle_no = 1234;
        tick(2);
        reset = 1'b0;
        chk("post_rst_occupancy", occupancy, 0);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_ready", ready, 1);
        tick(3);
        chk("no_false_edge_ready", ready, 1);
        chk("no_done_after_reset", done_cnt - d, 0);
        chk("no_lost_after_reset", lost_cnt - l, 0);
        car_parked = 1'b0;
        leave(1104, ST_NOT_FOUND, 0, 0);

        tick(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
